// File: rtl/hiscore_upload.sv
// Serves HPS ioctl upload reads from a core-side RAM read port, pausing the CPU
// for the duration so the saved image (e.g. a high-score table) is coherent.
module hiscore_upload #(
  parameter int         ADDR_W      = 10,
  parameter int         DEPTH       = 1024,
  parameter logic [7:0] INDEX       = 8'd4,
  parameter int         RAM_LATENCY = 1,
  parameter int         QUIESCE     = 16,
  parameter int         TIMEOUT     = 1 << 20
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              save_req,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_upload_req,
  output logic              pause_cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX_QL = (QUIESCE > RAM_LATENCY) ? QUIESCE : RAM_LATENCY;
  localparam int CNT_MAX    = (TIMEOUT > CNT_MAX_QL) ? TIMEOUT : CNT_MAX_QL;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [24:0] DEPTH_L = 25'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_QUIESCE, S_REQ, S_WAIT, S_SERVE, S_FETCH, S_DONE
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             save_d_reg;

  logic sel;
  logic save_edge;
  logic addr_in_range;

  assign sel           = ioctl_upload && (ioctl_index == INDEX);
  assign save_edge     = save_req && !save_d_reg;
  assign addr_in_range = (ioctl_addr < DEPTH_L);

  // One counter is shared by the quiesce delay, the host timeout and the RAM latency.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= '0;
      save_d_reg       <= 1'b0;
      ioctl_din        <= 8'h00;
      ioctl_upload_req <= 1'b0;
      pause_cpu        <= 1'b0;
      ram_addr         <= '0;
      ram_rd           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      save_d_reg       <= save_req;
      ram_rd           <= 1'b0;
      ioctl_upload_req <= 1'b0;
      done             <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          // A host-initiated upload takes precedence over a simultaneous user save.
          if (sel) begin
            state_reg <= S_SERVE;
            pause_cpu <= 1'b1;
            busy      <= 1'b1;
          end else if (save_edge) begin
            state_reg <= S_QUIESCE;
            pause_cpu <= 1'b1;
            busy      <= 1'b1;
            cnt_reg   <= CNT_W'(QUIESCE - 1);
          end
        end

        S_QUIESCE: begin
          if (cnt_reg == '0) state_reg <= S_REQ;
          else               cnt_reg   <= cnt_reg - CNT_W'(1);
        end

        S_REQ: begin
          ioctl_upload_req <= 1'b1;
          state_reg        <= S_WAIT;
          cnt_reg          <= CNT_W'(TIMEOUT);
        end

        S_WAIT: begin
          if (sel) begin
            state_reg <= S_SERVE;
          end else if (cnt_reg <= CNT_W'(1)) begin
            state_reg <= S_DONE;
            pause_cpu <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        S_SERVE: begin
          if (!sel) begin
            state_reg <= S_DONE;
            pause_cpu <= 1'b0;
            done      <= 1'b1;
          end else if (ioctl_rd) begin
            if (addr_in_range) begin
              ram_addr  <= ioctl_addr[ADDR_W-1:0];
              ram_rd    <= 1'b1;
              cnt_reg   <= CNT_W'(RAM_LATENCY);
              state_reg <= S_FETCH;
            end else begin
              ioctl_din <= 8'hFF;
            end
          end
        end

        S_FETCH: begin
          // A fetch in flight always completes, even if the host has already left.
          if (cnt_reg == '0) begin
            ioctl_din <= ram_data;
            if (sel) begin
              state_reg <= S_SERVE;
            end else begin
              state_reg <= S_DONE;
              pause_cpu <= 1'b0;
              done      <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= S_IDLE;
          pause_cpu <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hiscore_upload.sv
// Directed bench for hiscore_upload: user save, host reads, out-of-range reads,
// timeout, index filtering and asynchronous reset during a fetch.
module tb_hiscore_upload;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Main instance: RAM_LATENCY = 1
  logic        reset, save_req, ioctl_upload, ioctl_rd;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din, ram_data;
  logic        ioctl_upload_req, pause_cpu, ram_rd, busy, done;
  logic [9:0]  ram_addr;

  // Second instance: RAM_LATENCY = 3
  logic        rst3, save3, upl3, rd3;
  logic [24:0] addr3;
  logic [7:0]  din3, ram_data3;
  logic        upreq3, pause3, ram_rd3, busy3, done3;
  logic [9:0]  ram_addr3;

  logic [7:0] mem [0:1023];
  logic [7:0] p0, p1, p2;

  int checks = 0;
  int errors = 0;

  hiscore_upload #(.ADDR_W(10), .DEPTH(1024), .INDEX(8'd4), .RAM_LATENCY(1),
                   .QUIESCE(16), .TIMEOUT(40)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .save_req(save_req),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_upload_req(ioctl_upload_req),
    .pause_cpu(pause_cpu), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_data(ram_data),
    .busy(busy), .done(done)
  );

  hiscore_upload #(.ADDR_W(10), .DEPTH(1024), .INDEX(8'd4), .RAM_LATENCY(3),
                   .QUIESCE(16), .TIMEOUT(40)) u_dut3 (
    .clk_sys(clk_sys), .reset(rst3), .save_req(save3),
    .ioctl_upload(upl3), .ioctl_index(ioctl_index), .ioctl_rd(rd3),
    .ioctl_addr(addr3), .ioctl_din(din3), .ioctl_upload_req(upreq3),
    .pause_cpu(pause3), .ram_addr(ram_addr3), .ram_rd(ram_rd3), .ram_data(ram_data3),
    .busy(busy3), .done(done3)
  );

  // RAM models: one registered stage, and a three-stage pipeline
  always @(posedge clk_sys) if (ram_rd) ram_data <= mem[ram_addr];
  always @(posedge clk_sys) begin
    if (ram_rd3) p0 <= mem[ram_addr3];
    p1 <= p0;
    p2 <= p1;
  end
  assign ram_data3 = p2;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic read1(input logic [24:0] a, input logic [7:0] exp, input bit in_range);
    logic [7:0] prev;
    prev = ioctl_din;
    ioctl_rd = 1'b1; ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    checks++; if (ram_rd !== in_range) begin errors++; $display("FAIL read_ram_rd addr=%h: got %b want %b", a, ram_rd, in_range); end
    if (in_range) begin
      checks++; if (ram_addr !== a[9:0]) begin errors++; $display("FAIL read_ram_addr: got %h want %h", ram_addr, a[9:0]); end
      tick();
      checks++; if (ioctl_din !== prev) begin errors++; $display("FAIL read_early addr=%h: got %h want %h", a, ioctl_din, prev); end
      tick();
    end
    checks++; if (ioctl_din !== exp) begin errors++; $display("FAIL read_data addr=%h: got %h want %h", a, ioctl_din, exp); end
    $display("read addr=%h din=%h", a, ioctl_din);
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (ioctl_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h want 00", ioctl_din); end
    checks++; if ({ioctl_upload_req, pause_cpu, ram_rd, busy, done} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {ioctl_upload_req, pause_cpu, ram_rd, busy, done}); end
    checks++; if (ram_addr !== 10'd0) begin errors++; $display("FAIL reset_ram_addr: got %h want 000", ram_addr); end
    reset = 1'b0; rst3 = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || pause_cpu !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b pause=%b want 0 0", busy, pause_cpu); end
    $display("reset released");
  endtask

  task automatic wait_upload_req();
    int n;
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    checks++; if (pause_cpu !== 1'b1) begin errors++; $display("FAIL save_pause: got %b want 1", pause_cpu); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL save_busy: got %b want 1", busy); end
    n = 0;
    while (ioctl_upload_req !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n != 17) begin errors++; $display("FAIL upload_req_delay: got %0d want 17", n); end
    $display("upload_req after %0d cycles", n);
  endtask

  task automatic test_user_save();
    wait_upload_req();
    tick();
    checks++; if (ioctl_upload_req !== 1'b0) begin errors++; $display("FAIL upload_req_pulse: got %b want 0", ioctl_upload_req); end
    ioctl_index = 8'd4; ioctl_upload = 1'b1;
    tick();
    checks++; if (pause_cpu !== 1'b1) begin errors++; $display("FAIL serve_pause: got %b want 1", pause_cpu); end
    for (int i = 0; i < 4; i++) read1(25'(i), 8'(8'hA0 + i), 1'b1);
  endtask

  task automatic test_out_of_range();
    read1(25'd1024, 8'hFF, 1'b0);
    read1(25'd1, 8'hA1, 1'b1);
    read1(25'h100000, 8'hFF, 1'b0);
  endtask

  task automatic test_save_during_serve();
    bit seen;
    seen = 1'b0;
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    repeat (25) begin tick(); if (ioctl_upload_req === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL save_in_serve_req: got %b want 0", seen); end
    checks++; if (pause_cpu !== 1'b1) begin errors++; $display("FAIL save_in_serve_pause: got %b want 1", pause_cpu); end
    $display("save during serve ignored=%b", !seen);
  endtask

  task automatic test_end_upload();
    ioctl_upload = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL end_done: got %b want 1", done); end
    checks++; if (pause_cpu !== 1'b0) begin errors++; $display("FAIL end_pause: got %b want 0", pause_cpu); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL end_idle: got done=%b busy=%b want 0 0", done, busy); end
    $display("upload ended");
  endtask

  task automatic test_timeout();
    int n;
    wait_upload_req();
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n != 40) begin errors++; $display("FAIL timeout_delay: got %0d want 40", n); end
    checks++; if (pause_cpu !== 1'b0) begin errors++; $display("FAIL timeout_pause: got %b want 0", pause_cpu); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b done=%b want 0 0", busy, done); end
    $display("timeout after %0d cycles", n);
  endtask

  task automatic test_host_index();
    ioctl_index = 8'd3; ioctl_upload = 1'b1;
    repeat (5) tick();
    checks++; if (pause_cpu !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wrong_index_idle: got pause=%b busy=%b want 0 0", pause_cpu, busy); end
    ioctl_rd = 1'b1; ioctl_addr = 25'd0;
    tick();
    ioctl_rd = 1'b0;
    checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL wrong_index_ram_rd: got %b want 0", ram_rd); end
    tick(); tick();
    ioctl_index = 8'd4;
    tick();
    checks++; if (pause_cpu !== 1'b1) begin errors++; $display("FAIL host_pause: got %b want 1", pause_cpu); end
    read1(25'd5, 8'hA5, 1'b1);
    ioctl_upload = 1'b0;
    tick();
    checks++; if (done !== 1'b1 || pause_cpu !== 1'b0) begin errors++; $display("FAIL host_end: got done=%b pause=%b want 1 0", done, pause_cpu); end
    tick();
  endtask

  task automatic test_reset_fetch();
    bit seen;
    upl3 = 1'b1;
    tick(); tick();
    rd3 = 1'b1; addr3 = 25'd7;
    tick();
    rd3 = 1'b0;
    checks++; if (ram_rd3 !== 1'b1) begin errors++; $display("FAIL lat3_ram_rd: got %b want 1", ram_rd3); end
    repeat (3) tick();
    checks++; if (din3 !== 8'h00) begin errors++; $display("FAIL lat3_early: got %h want 00", din3); end
    tick();
    checks++; if (din3 !== 8'hA7) begin errors++; $display("FAIL lat3_data: got %h want a7", din3); end
    $display("lat3 read addr=007 din=%h", din3);
    tick(); tick();
    rd3 = 1'b1; addr3 = 25'd2;
    tick();
    rd3 = 1'b0;
    tick();
    rst3 = 1'b1;
    #1;
    checks++; if (din3 !== 8'h00) begin errors++; $display("FAIL rst_fetch_din: got %h want 00", din3); end
    checks++; if ({upreq3, pause3, ram_rd3, busy3, done3} !== 5'b0) begin errors++; $display("FAIL rst_fetch_flags: got %b want 00000", {upreq3, pause3, ram_rd3, busy3, done3}); end
    checks++; if (ram_addr3 !== 10'd0) begin errors++; $display("FAIL rst_fetch_addr: got %h want 000", ram_addr3); end
    tick();
    rst3 = 1'b0; upl3 = 1'b0;
    seen = 1'b0;
    repeat (8) begin tick(); if (done3 === 1'b1 || din3 !== 8'h00) seen = 1'b1; end
    checks++; if (seen !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL rst_fetch_after: got seen=%b busy=%b want 0 0", seen, busy3); end
    $display("reset mid-fetch din=%h", din3);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(8'hA0 + i);
    reset = 1'b1; rst3 = 1'b1;
    save_req = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = '0;
    save3 = 1'b0; upl3 = 1'b0; rd3 = 1'b0; addr3 = '0;

    test_reset();
    test_user_save();
    test_out_of_range();
    test_save_during_serve();
    test_end_upload();
    test_timeout();
    test_host_index();
    test_reset_fetch();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
